multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multicycle MIPS core. Sequences one instruction through
//  FETCH/DECODE/EXEC/MEM/WB and drives the PC register's write enable and next-PC
//  select, plus IR, memory, regfile and ALU mux controls. Waits on a memory ready
//  handshake. Sits between the IR opcode/funct fields and the datapath.
// PARAMETERS
//  ALUOP_W   3   width of alu_op
//  STATE_W   4   width of state encoding / state_out
// PORTS
//  clk          in   1        core clock, all state on rising edge
//  rst          in   1        synchronous, active-high reset
//  opcode       in   6        IR[31:26]
//  funct        in   6        IR[5:0]
//  zero         in   1        ALU zero flag (valid in BRANCH)
//  mem_ready    in   1        memory completes access this cycle
//  pc_write     out  1        PC load enable (to PC PCWrite)
//  pc_source    out  2        00 ALU(PC+4), 01 ALUOut(branch), 10 jump tgt, 11 rs
//  ir_write     out  1        latch instruction
//  mem_read     out  1        memory read request
//  mem_write    out  1        memory write request
//  reg_write    out  1        regfile write enable
//  reg_dst      out  2        00 rt, 01 rd, 10 $31
//  mem_to_reg   out  2        00 ALUOut, 01 MDR, 10 PC(+4)
//  alu_src_a    out  1        0 PC, 1 rs
//  alu_src_b    out  2        00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ext_op       out  2        00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
//  alu_op       out  ALUOP_W  000 add, 001 sub, 010 or, 011 slt, 100 pass B
//  illegal_op   out  1        1-cycle pulse on unknown opcode/funct in DECODE
//  state_out    out  STATE_W  current state, debug
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXEC_R=2 EXEC_I=3 ADDR=4 MEM_RD=5 MEM_WB=6 MEM_WR=7
//   BRANCH=8 JUMP=9 ALU_WB=10. Outputs are Moore (state) plus mem_ready/zero gating.
//  Reset: state<=FETCH; while rst=1 every enable (pc_write, ir_write, mem_*,
//   reg_write) is forced 0; selects 0; illegal_op 0. Reset mid-instruction aborts it.
//  FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
//   Hold until mem_ready; on mem_ready: ir_write=1, pc_write=1, ->DECODE.
//  DECODE: alu_src_b=11, ext_op=01 (branch target precompute). Dispatch:
//   R(000000) addu 100001/subu 100011/slt 101010 ->EXEC_R; jr 001000 ->JUMP;
//   ori 001101, lui 001111 ->EXEC_I; lw 100011, sw 101011 ->ADDR; beq 000100 ->BRANCH;
//   j 000010, jal 000011 ->JUMP; else illegal_op=1, ->FETCH (treated as NOP).
//  EXEC_R: alu_src_a=1, alu_src_b=00, alu_op per funct ->ALU_WB(reg_dst=01).
//  EXEC_I: alu_src_a=1, alu_src_b=10; ori: ext_op=00 alu_op=or; lui: ext_op=10
//   alu_op=passB ->ALU_WB(reg_dst=00). ALU_WB: reg_write=1, mem_to_reg=00 ->FETCH.
//  ADDR: alu_src_a=1, alu_src_b=10, ext_op=01, add; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD: mem_read=1, hold until mem_ready ->MEM_WB. MEM_WB: reg_write=1,
//   reg_dst=00, mem_to_reg=01 ->FETCH.
//  MEM_WR: mem_write=1 held until mem_ready ->FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write=zero ->FETCH.
//  JUMP: pc_write=1; j/jal pc_source=10, jr 11; jal also reg_write=1, reg_dst=10,
//   mem_to_reg=10 (PC already +4) ->FETCH.
//  Opcode/funct sampled only in DECODE and later held stable by IR (ir_write=0).
//  CPI with mem_ready=1: R/I/beq/j 3-4; lw 5; sw 4. Wait cycles add 1 each.
//  Unused states 11..15: ->FETCH next cycle, all enables 0.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/funct constants, state encodings, alu_op,
//   pc_source, reg_dst, mem_to_reg, alu_src_b, ext_op select codes.
//  Sub-module ctrl_decode (combinational opcode/funct -> instr class, illegal).
//  FSM + output decode in multicycle_ctrl; single always block for state register.
// TESTING
//  rst=1 two cycles, mem_ready=1 -> state_out=0, all enables 0 during rst.
//  addu (op 0, funct 21h) -> FETCH,DECODE,EXEC_R,ALU_WB; reg_write=1 reg_dst=01 in cycle 4.
//  lw (23h), mem_ready low 2 cycles in MEM_RD -> 7 cycles, mem_to_reg=01 in MEM_WB.
//  beq (04h) zero=1 -> pc_write=1 pc_source=01 in BRANCH; zero=0 -> pc_write=0.
//  jal (03h) -> JUMP: pc_write=1 pc_source=10 reg_write=1 reg_dst=10 mem_to_reg=10.
//  opcode 3Fh -> illegal_op pulse in DECODE, next state FETCH; rst in MEM_WR -> no mem_write.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, decoded instruction classes and datapath select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WB = 4'd6,
        ST_MEM_WR = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_ALU_WB = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_NONE, CLS_ADDU, CLS_SUBU, CLS_SLT, CLS_JR, CLS_ORI, CLS_LUI,
        CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JAL
    } instr_cls_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;

    localparam logic [1:0] PCS_PC4    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // First execution state for each decoded class; unknown classes fall back to FETCH.
    function automatic state_t dispatch(input instr_cls_t cls);
        case (cls)
            CLS_ADDU, CLS_SUBU, CLS_SLT: return ST_EXEC_R;
            CLS_ORI, CLS_LUI:            return ST_EXEC_I;
            CLS_LW, CLS_SW:              return ST_ADDR;
            CLS_BEQ:                     return ST_BRANCH;
            CLS_J, CLS_JAL, CLS_JR:      return ST_JUMP;
            default:                     return ST_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier; flags anything outside the supported subset.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output instr_cls_t  cls,
    output logic        illegal
);

    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CLS_ADDU;
                    FN_SUBU: cls = CLS_SUBU;
                    FN_SLT:  cls = CLS_SLT;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_NONE;
                endcase
            end
            OP_ORI:  cls = CLS_ORI;
            OP_LUI:  cls = CLS_LUI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_NONE;
        endcase
        illegal = (cls == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives the datapath enables and mux selects from the current state.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic [1:0]         pc_source,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    state_t     state_reg;
    instr_cls_t cls_reg;
    instr_cls_t dec_cls;
    logic       dec_illegal;
    logic [2:0] alu_op_c;

    ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    // The class is captured in DECODE so later states never depend on the raw IR fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            cls_reg   <= CLS_NONE;
        end else begin
            case (state_reg)
                ST_FETCH:  if (mem_ready) state_reg <= ST_DECODE;
                ST_DECODE: begin
                    cls_reg   <= dec_cls;
                    state_reg <= dispatch(dec_cls);
                end
                ST_EXEC_R: state_reg <= ST_ALU_WB;
                ST_EXEC_I: state_reg <= ST_ALU_WB;
                ST_ADDR:   state_reg <= (cls_reg == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD: if (mem_ready) state_reg <= ST_MEM_WB;
                ST_MEM_WR: if (mem_ready) state_reg <= ST_FETCH;
                default:   state_reg <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_source  = PCS_PC4;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_op     = EXT_ZERO;
        alu_op_c   = ALU_ADD;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b  = SRCB_IMMSH;
                    ext_op     = EXT_SIGN;
                    illegal_op = dec_illegal;
                end
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (cls_reg)
                        CLS_SUBU: alu_op_c = ALU_SUB;
                        CLS_SLT:  alu_op_c = ALU_SLT;
                        default:  alu_op_c = ALU_ADD;
                    endcase
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = (cls_reg == CLS_LUI) ? EXT_LUI : EXT_ZERO;
                    alu_op_c  = (cls_reg == CLS_LUI) ? ALU_PASSB : ALU_OR;
                end
                ST_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = (cls_reg == CLS_ORI || cls_reg == CLS_LUI) ? RD_RT : RD_RD;
                end
                ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ext_op    = EXT_SIGN;
                end
                ST_MEM_RD: mem_read = 1'b1;
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                ST_MEM_WR: mem_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op_c  = ALU_SUB;
                    pc_source = PCS_BRANCH;
                    pc_write  = zero;
                end
                ST_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = (cls_reg == CLS_JR) ? PCS_RS : PCS_JUMP;
                    if (cls_reg == CLS_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op    = ALUOP_W'(alu_op_c);
    assign state_out = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction step-table model is checked
// against the DUT every cycle, plus hand-computed literal probes.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, ext_op;
    logic [2:0] alu_op;
    logic [3:0] state_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int idx_m = 0;
    bit chk_en = 1'b0;

    multicycle_ctrl #(.ALUOP_W(3), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .alu_op(alu_op), .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Step sequence of each instruction as listed state numbers; -1 terminates.
    function automatic int path(input logic [5:0] op, input logic [5:0] fn, input int idx);
        int p[5];
        p = '{0, 1, -1, -1, -1};
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h2a)) p = '{0, 1, 2, 10, -1};
        else if (op == 6'h00 && fn == 6'h08)                              p = '{0, 1, 9, -1, -1};
        else if (op == 6'h0d || op == 6'h0f)                              p = '{0, 1, 3, 10, -1};
        else if (op == 6'h23)                                             p = '{0, 1, 4, 5, 6};
        else if (op == 6'h2b)                                             p = '{0, 1, 4, 7, -1};
        else if (op == 6'h04)                                             p = '{0, 1, 8, -1, -1};
        else if (op == 6'h02 || op == 6'h03)                              p = '{0, 1, 9, -1, -1};
        return (idx >= 0 && idx < 5) ? p[idx] : -1;
    endfunction

    function automatic bit is_wait(input int ph);
        return (ph == 0 || ph == 5 || ph == 7);
    endfunction

    // Expected output bundle:
    // {pc_write,pc_source,ir_write,mem_read,mem_write,reg_write,reg_dst,mem_to_reg,
    //  alu_src_a,alu_src_b,ext_op,alu_op,illegal_op,state}
    function automatic logic [23:0] model_out(input int ph, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z,
                                              input logic mr, input logic r);
        logic pw, irw, mrd, mwr, rw, sa, ill;
        logic [1:0] ps, rd, m2r, sb, ext;
        logic [2:0] aop;
        logic [3:0] st;
        {pw, irw, mrd, mwr, rw, sa, ill} = '0;
        {ps, rd, m2r, sb, ext} = '0;
        aop = 3'd0;
        st = 4'(ph);
        if (!r) begin
            case (ph)
                0: begin mrd = 1'b1; sb = 2'd1; irw = mr; pw = mr; end
                1: begin sb = 2'd3; ext = 2'd1; ill = (path(op, fn, 2) < 0); end
                2: begin sa = 1'b1; aop = (fn == 6'h23) ? 3'd1 : (fn == 6'h2a) ? 3'd3 : 3'd0; end
                3: begin
                    sa = 1'b1; sb = 2'd2;
                    ext = (op == 6'h0f) ? 2'd2 : 2'd0;
                    aop = (op == 6'h0f) ? 3'd4 : 3'd2;
                end
                4: begin sa = 1'b1; sb = 2'd2; ext = 2'd1; end
                5: mrd = 1'b1;
                6: begin rw = 1'b1; m2r = 2'd1; end
                7: mwr = 1'b1;
                8: begin sa = 1'b1; aop = 3'd1; ps = 2'd1; pw = z; end
                9: begin
                    pw = 1'b1;
                    ps = (op == 6'h00) ? 2'd3 : 2'd2;
                    if (op == 6'h03) begin rw = 1'b1; rd = 2'd2; m2r = 2'd2; end
                end
                10: begin rw = 1'b1; rd = (op == 6'h00) ? 2'd1 : 2'd0; end
                default: ;
            endcase
        end
        return {pw, ps, irw, mrd, mwr, rw, rd, m2r, sa, sb, ext, aop, ill, st};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) idx_m <= 0;
        else if (!(is_wait(path(opcode, funct, idx_m)) && !mem_ready))
            idx_m <= (path(opcode, funct, idx_m + 1) < 0) ? 0 : idx_m + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [23:0] exp_v, act_v;
            exp_v = model_out(path(opcode, funct, idx_m), opcode, funct, zero, mem_ready, rst);
            act_v = {pc_write, pc_source, ir_write, mem_read, mem_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal_op, state_out};
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL cycle %0d outputs: got %h expected %h (op %h fn %h)",
                         cyc, act_v, exp_v, opcode, funct);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    task automatic step(input int n, input logic [15:0] rdy);
        for (int c = 0; c < n; c++) begin
            mem_ready = rdy[c];
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
    endtask

    task automatic check_end(input string name);
        check({name, " back in FETCH"}, 32'(state_out), 32'd0);
        check({name, " model idle"}, 32'(idx_m), 32'd0);
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset state", 32'(state_out), 32'd0);
        check("reset enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(6'h00, 6'h21, 1'b0); step(3, '1);
        check("addu ALU_WB reg_write/reg_dst", {reg_write, reg_dst}, 32'b101);
        step(1, '1); check_end("addu");

        issue(6'h00, 6'h23, 1'b0); step(2, '1);
        check("subu alu_op", 32'(alu_op), 32'd1);
        step(2, '1); check_end("subu");

        issue(6'h00, 6'h2a, 1'b0); step(2, '1);
        check("slt alu_op", 32'(alu_op), 32'd3);
        step(2, '1); check_end("slt");

        issue(6'h23, 6'h00, 1'b0); step(3, '1); step(3, 16'b100);
        check("lw MEM_WB state", 32'(state_out), 32'd6);
        check("lw mem_to_reg", 32'(mem_to_reg), 32'b01);
        step(1, '1); check_end("lw 7 cycles");

        issue(6'h2b, 6'h00, 1'b0); step(1, 16'b0); step(4, '1); check_end("sw fetch wait");

        issue(6'h04, 6'h00, 1'b1); step(2, '1);
        check("beq taken pc_write/pc_source", {pc_write, pc_source}, 32'b101);
        step(1, '1); check_end("beq taken");

        issue(6'h04, 6'h00, 1'b0); step(2, '1);
        check("beq not taken pc_write/pc_source", {pc_write, pc_source}, 32'b001);
        step(1, '1); check_end("beq not taken");

        issue(6'h03, 6'h00, 1'b0); step(2, '1);
        check("jal controls", {pc_write, pc_source, reg_write, reg_dst, mem_to_reg}, 32'b11011010);
        step(1, '1); check_end("jal");

        issue(6'h02, 6'h00, 1'b0); step(2, '1);
        check("j pc_source/reg_write", {pc_source, reg_write}, 32'b100);
        step(1, '1); check_end("j");

        issue(6'h00, 6'h08, 1'b0); step(2, '1);
        check("jr pc_source", 32'(pc_source), 32'b11);
        step(1, '1); check_end("jr");

        issue(6'h0d, 6'h00, 1'b0); step(2, '1);
        check("ori ext_op/alu_op", {ext_op, alu_op}, 32'b00010);
        step(2, '1); check_end("ori");

        issue(6'h0f, 6'h00, 1'b0); step(2, '1);
        check("lui ext_op/alu_op", {ext_op, alu_op}, 32'b10100);
        step(2, '1); check_end("lui");

        issue(6'h3f, 6'h00, 1'b0); step(1, '1);
        check("illegal opcode pulse", 32'(illegal_op), 32'd1);
        step(1, '1);
        check("illegal pulse cleared", 32'(illegal_op), 32'd0);
        check_end("illegal opcode");

        issue(6'h00, 6'h3f, 1'b0); step(1, '1);
        check("illegal funct pulse", 32'(illegal_op), 32'd1);
        step(1, '1); check_end("illegal funct");

        issue(6'h2b, 6'h00, 1'b0); step(3, '1);
        check("sw MEM_WR mem_write", 32'(mem_write), 32'd1);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst in MEM_WR mem_write", 32'(mem_write), 32'd0);
        step(1, 16'b0);
        rst = 1'b0;
        check_end("sw aborted by rst");

        issue(6'h00, 6'h21, 1'b0); step(4, '1); check_end("addu after abort");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
